// File: rtl/mprj_enable_seq.sv
// -----------------------------------------------------------------------------
// mprj_enable_seq
//
// Purpose
//   Staged power-up / power-down sequencer for the user-project enables.
//   The WIDTH enable lines are switched in groups of GROUP bits, one group
//   every STEP clock cycles, so the user area never sees all of its enables
//   toggle on a single edge. Every enable is additionally gated by its own
//   tie-high input, and any loss of a tie-high while the block is active drops
//   all enables at once and latches a fault.
//
// Ports
//   wb_clk_i   in   1      single clock, all state changes on its rising edge
//   wb_rstn_i  in   1      synchronous active-low reset
//   HI         in   WIDTH  tie-high vector, every bit expected to be 1
//   start      in   1      level request to ramp enables up (looked at in IDLE)
//   stop       in   1      level request to ramp enables down
//   fault_clr  in   1      fault-clear request (looked at in FAULT)
//   en_o       out  WIDTH  registered gated enables toward the user area
//   ready      out  1      all groups enabled (ON)
//   busy       out  1      sequencing in progress (CHECK, RAMP_UP, RAMP_DOWN)
//   fault      out  1      sticky fault flag (FAULT)
//   dbg_state  out  3      current FSM state encoding, for observation only
//
// Request semantics
//   There is no valid/ready handshake here: start, stop and fault_clr are
//   level requests sampled on every rising edge. A request is acted on only
//   in the states listed above; outside those states it is simply ignored and
//   nothing is queued. When start and stop are both high, stop wins. A tie-high
//   failure outranks any request.
//
// Output timing
//   en_o, ready and busy are registered from the current state and group
//   counter, so they trail the FSM by one edge. The fault path is the
//   exception: entering FAULT clears en_o and ready and sets fault on the same
//   edge the FSM moves, so enables drop as early as possible.
// -----------------------------------------------------------------------------
module mprj_enable_seq #(
  parameter int WIDTH = 463,
  parameter int GROUP = 32,
  parameter int STEP  = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rstn_i,
  input  logic [WIDTH-1:0] HI,
  input  logic             start,
  input  logic             stop,
  input  logic             fault_clr,
  output logic [WIDTH-1:0] en_o,
  output logic             ready,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       dbg_state
);

  // Number of groups; the last one may be partial.
  localparam int NG   = (WIDTH + GROUP - 1) / GROUP;
  localparam int GC_W = $clog2(NG + 1);
  localparam int SC_W = (STEP > 1) ? $clog2(STEP) : 1;

  localparam logic [GC_W-1:0] GC_ONE  = GC_W'(1);
  localparam logic [GC_W-1:0] GC_LAST = GC_W'(NG - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STEP - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    RAMP_UP   = 3'd2,
    ON        = 3'd3,
    RAMP_DOWN = 3'd4,
    FAULT     = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [GC_W-1:0] gc_q, gc_d;   // number of groups currently enabled, 0..NG
  logic [SC_W-1:0] sc_q, sc_d;   // cycles spent on the current group, 0..STEP-1
  logic            hi_ok_q;      // all tie-highs present, one cycle behind HI
  logic [WIDTH-1:0] grp_en;      // per-bit "my group is below gc" mask

  // Saturating decrement keeps gc from wrapping below zero even if an
  // unexpected state/counter combination is ever reached.
  function automatic logic [GC_W-1:0] gc_dec(input logic [GC_W-1:0] v);
    return (v == '0) ? '0 : v - GC_ONE;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    gc_d    = gc_q;
    sc_d    = '0;    // sc only runs while ramping

    unique case (state_q)
      IDLE: begin
        gc_d = '0;
        if (start && !stop) state_d = CHECK;
      end

      CHECK: begin
        gc_d = '0;
        if (!hi_ok_q) begin
          state_d = FAULT;
        end else if (stop) begin
          state_d = IDLE;
        end else begin
          // First group goes on immediately; a single-group build is done.
          gc_d    = GC_ONE;
          state_d = (NG == 1) ? ON : RAMP_UP;
        end
      end

      RAMP_UP: begin
        if (!hi_ok_q) begin
          state_d = FAULT;
          gc_d    = '0;
        end else if (stop) begin
          // Abort: drop one group now and walk the rest down.
          gc_d    = gc_dec(gc_q);
          state_d = (gc_q <= GC_ONE) ? IDLE : RAMP_DOWN;
        end else if (sc_q == SC_LAST) begin
          if (gc_q >= GC_LAST) begin
            gc_d    = GC_W'(NG);
            state_d = ON;
          end else begin
            gc_d = gc_q + GC_ONE;
          end
        end else begin
          sc_d = sc_q + SC_W'(1);
        end
      end

      ON: begin
        if (!hi_ok_q) begin
          state_d = FAULT;
          gc_d    = '0;
        end else if (stop) begin
          gc_d    = gc_dec(gc_q);
          state_d = (gc_q <= GC_ONE) ? IDLE : RAMP_DOWN;
        end
      end

      RAMP_DOWN: begin
        if (!hi_ok_q) begin
          state_d = FAULT;
          gc_d    = '0;
        end else if (sc_q == SC_LAST) begin
          gc_d = gc_dec(gc_q);
          if (gc_q <= GC_ONE) state_d = IDLE;
        end else begin
          sc_d = sc_q + SC_W'(1);
        end
      end

      FAULT: begin
        gc_d = '0;
        // Clearing only succeeds once the tie-highs are back.
        if (fault_clr && hi_ok_q) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        gc_d    = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Group mask: bit b belongs to group b/GROUP and is enabled while that group
  // index is below gc. The last group naturally stops at WIDTH-1.
  // ---------------------------------------------------------------------------
  for (genvar b = 0; b < WIDTH; b++) begin : g_mask
    assign grp_en[b] = (gc_q > GC_W'(b / GROUP));
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      state_q <= IDLE;
      gc_q    <= '0;
      sc_q    <= '0;
      hi_ok_q <= 1'b0;
      en_o    <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      gc_q    <= gc_d;
      sc_q    <= sc_d;
      hi_ok_q <= &HI;
      en_o    <= (state_d == FAULT) ? '0 : (HI & grp_en);
      // ready drops on the very edge that leaves ON.
      ready   <= (state_q == ON) && (state_d == ON);
      busy    <= (state_q == CHECK) || (state_q == RAMP_UP) ||
                 (state_q == RAMP_DOWN);
      fault   <= (state_d == FAULT);
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mprj_enable_seq.sv
// -----------------------------------------------------------------------------
// Testbench for mprj_enable_seq.
// A small instance (WIDTH=8, GROUP=4, STEP=2) is driven with directed and
// random stimulus and compared every cycle against a behavioural model that
// tracks ramp progress as elapsed cycles. A default-parameter instance checks
// the full-size ramp timing.
// -----------------------------------------------------------------------------
module tb_mprj_enable_seq;

  localparam int W   = 8;
  localparam int G   = 4;
  localparam int S   = 2;
  localparam int NGS = 2;
  localparam int BW  = 463;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn;
  logic [W-1:0] hi;
  logic         start, stop, fault_clr;
  logic [W-1:0] en;
  logic         ready, busy, fault;
  logic [2:0]   dbg;

  logic [BW-1:0] hi_b, en_b;
  logic          start_b, stop_b, fclr_b, ready_b, busy_b, fault_b;
  logic [2:0]    dbg_b;

  mprj_enable_seq #(.WIDTH(W), .GROUP(G), .STEP(S)) dut (
    .wb_clk_i (clk),
    .wb_rstn_i(rstn),
    .HI       (hi),
    .start    (start),
    .stop     (stop),
    .fault_clr(fault_clr),
    .en_o     (en),
    .ready    (ready),
    .busy     (busy),
    .fault    (fault),
    .dbg_state(dbg)
  );

  mprj_enable_seq dut_big (
    .wb_clk_i (clk),
    .wb_rstn_i(rstn),
    .HI       (hi_b),
    .start    (start_b),
    .stop     (stop_b),
    .fault_clr(fclr_b),
    .en_o     (en_b),
    .ready    (ready_b),
    .busy     (busy_b),
    .fault    (fault_b),
    .dbg_state(dbg_b)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: mode plus elapsed cycles in the current ramp phase.
  // ---------------------------------------------------------------------------
  localparam int M_IDLE = 0, M_CHECK = 1, M_UP = 2, M_ON = 3, M_DOWN = 4,
                 M_FAULT = 5;

  int   m_mode = M_IDLE;
  int   m_base = 0;   // groups on when the phase started
  int   m_t    = 0;   // cycles elapsed in the phase
  logic m_hiok = 1'b0;

  logic [W+2:0] exp_q[$];   // {en_o, ready, busy, fault}

  function automatic int cur_gc();
    case (m_mode)
      M_UP:    return m_base + m_t / S;
      M_ON:    return NGS;
      M_DOWN:  return m_base - m_t / S;
      default: return 0;
    endcase
  endfunction

  function automatic logic [W-1:0] low_mask(input int groups);
    logic [63:0] one;
    one = 64'd1;
    if (groups * G >= W) return '1;
    return W'((one << (groups * G)) - 64'd1);
  endfunction

  task automatic model_edge(input logic r, input logic [W-1:0] h,
                            input logic s, input logic p, input logic c);
    int gc, nmode;
    logic [W-1:0] e;
    logic busy_e;
    if (!r) begin
      m_mode = M_IDLE; m_base = 0; m_t = 0; m_hiok = 1'b0;
      exp_q.push_back('0);
      return;
    end
    gc     = cur_gc();
    busy_e = (m_mode == M_CHECK) || (m_mode == M_UP) || (m_mode == M_DOWN);
    nmode  = m_mode;
    if ((m_mode inside {M_CHECK, M_UP, M_ON, M_DOWN}) && !m_hiok) begin
      nmode = M_FAULT;
    end else begin
      case (m_mode)
        M_IDLE:  if (s && !p) nmode = M_CHECK;
        M_CHECK: begin
          if (p) nmode = M_IDLE;
          else begin
            m_base = 1; m_t = 0;
            nmode = (1 >= NGS) ? M_ON : M_UP;
          end
        end
        M_UP: begin
          if (p) begin
            m_base = gc - 1; m_t = 0;
            nmode = (m_base == 0) ? M_IDLE : M_DOWN;
          end else begin
            m_t++;
            if (m_base + m_t / S >= NGS) nmode = M_ON;
          end
        end
        M_ON: begin
          if (p) begin
            m_base = NGS - 1; m_t = 0;
            nmode = (m_base == 0) ? M_IDLE : M_DOWN;
          end
        end
        M_DOWN: begin
          m_t++;
          if (m_base - m_t / S <= 0) nmode = M_IDLE;
        end
        M_FAULT: if (c && m_hiok) nmode = M_IDLE;
        default: nmode = M_IDLE;
      endcase
    end
    e = (nmode == M_FAULT) ? '0 : (h & low_mask(gc));
    exp_q.push_back({e, (m_mode == M_ON) && (nmode == M_ON), busy_e,
                     nmode == M_FAULT});
    m_mode = nmode;
    m_hiok = &h;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply inputs, step the model, clock, compare.
  // ---------------------------------------------------------------------------
  task automatic cycle(input logic r, input logic [W-1:0] h, input logic s,
                       input logic p, input logic c);
    logic [W+2:0] exp;
    rstn = r; hi = h; start = s; stop = p; fault_clr = c;
    model_edge(r, h, s, p, c);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check("en_o",  512'(en),    512'(exp[W+2:3]));
    check("ready", 512'(ready), 512'(exp[2]));
    check("busy",  512'(busy),  512'(exp[1]));
    check("fault", 512'(fault), 512'(exp[0]));
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0] h;
    logic r, s, p, c;
    logic [BW-1:0] prev, diff, exp_last;
    int steps, ready_edge;

    rstn = 1'b0; hi = 8'hFF; start = 1'b0; stop = 1'b0; fault_clr = 1'b0;
    hi_b = '1; start_b = 1'b0; stop_b = 1'b0; fclr_b = 1'b0;

    // Reset state
    cycle(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    check("rst_en_o",  512'(en),    512'(0));
    check("rst_fault", 512'(fault), 512'(0));
    idle_n(1);

    // Ramp up: start at edge 0
    cycle(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    idle_n(1);
    check("up_busy_e1", 512'(busy), 512'(1));
    idle_n(1);
    check("up_en_e2", 512'(en), 512'(8'h0F));
    idle_n(2);
    check("up_en_e4",    512'(en),    512'(8'hFF));
    check("up_ready_e4", 512'(ready), 512'(1));
    check("up_busy_e4",  512'(busy),  512'(0));

    // Ramp down: stop at edge 0
    cycle(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
    idle_n(1);
    check("dn_en_e1",    512'(en),    512'(8'h0F));
    check("dn_ready_e1", 512'(ready), 512'(0));
    idle_n(2);
    check("dn_en_e3",   512'(en),   512'(8'h00));
    check("dn_busy_e3", 512'(busy), 512'(0));

    // Fault from ON, failed clear, then good clear
    cycle(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    idle_n(5);
    cycle(1'b1, 8'hDF, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hDF, 1'b0, 1'b0, 1'b0);
    check("flt_set",   512'(fault), 512'(1));
    check("flt_en",    512'(en),    512'(0));
    cycle(1'b1, 8'hDF, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'hDF, 1'b0, 1'b0, 1'b1);
    check("flt_hold", 512'(fault), 512'(1));
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    check("flt_clr", 512'(fault), 512'(0));
    idle_n(1);

    // start and stop together in IDLE
    cycle(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
    idle_n(1);
    check("both_busy", 512'(busy), 512'(0));
    check("both_en",   512'(en),   512'(0));

    // stop at edge 3 of a ramp-up
    cycle(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    idle_n(2);
    cycle(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
    idle_n(3);
    check("abort_en_e6",   512'(en),   512'(0));
    check("abort_busy_e6", 512'(busy), 512'(0));

    // Reset at edge 3 of a ramp-up, start held during reset
    cycle(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    idle_n(2);
    cycle(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    check("rst_mid_en",   512'(en),   512'(0));
    check("rst_mid_busy", 512'(busy), 512'(0));
    cycle(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    idle_n(2);
    check("rst_ign_busy", 512'(busy), 512'(0));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      h = 8'hFF;
      if ($urandom_range(39) == 0) h[$urandom_range(W - 1)] = 1'b0;
      r = ($urandom_range(199) != 0);
      s = ($urandom_range(3) == 0);
      p = ($urandom_range(11) == 0);
      c = ($urandom_range(3) == 0);
      cycle(r, h, s, p, c);
    end

    // Full-size instance: ramp timing and group boundaries
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    prev = en_b; steps = 0; ready_edge = -1; diff = '0;
    exp_last = '0;
    for (int b = 448; b < BW; b++) exp_last[b] = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (en_b !== prev) begin
        check("big_step_edge", 512'(i), 512'(2 + steps * 16));
        steps++;
        diff = en_b & ~prev;
        prev = en_b;
      end
      if (ready_b && ready_edge < 0) ready_edge = i;
    end
    check("big_ready_edge", 512'(ready_edge), 512'(226));
    check("big_steps",      512'(steps),      512'(15));
    check("big_last_grp",   512'(diff),       512'(exp_last));
    check("big_all_on",     512'(en_b),       512'({BW{1'b1}}));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
